uart_loopback_checker: RTL and testbench

- Synthesisable traffic generator and checker for UART echo paths.
- Drives a uart_tx-style handshake with a programmable byte pattern.
- Monitors a uart_rx-style output and compares each echoed frame against a regenerated expected stream.
- Reports sent, received and error counts, plus pass/timeout status; lets echo designs self-test on hardware without a bench.

---
 rtl/uart_lb_pkg.sv | 15 +
 rtl/uart_lb_pattern_gen.sv | 44 ++++
 rtl/uart_loopback_checker.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_loopback_checker.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_lb_pkg.sv
// Shared constants for the UART loopback checker: pattern mode codes and FSM states.
package uart_lb_pkg;

  localparam logic [1:0] LB_MODE_INC = 2'd0;
  localparam logic [1:0] LB_MODE_ROL = 2'd1;
  localparam logic [1:0] LB_MODE_INV = 2'd2;

  typedef enum logic [1:0] {
    LB_IDLE  = 2'd0,
    LB_SEND  = 2'd1,
    LB_DRAIN = 2'd2,
    LB_DONE  = 2'd3
  } lb_state_e;

endpackage

// File: rtl/uart_lb_pattern_gen.sv
// Programmable byte-pattern generator; used both for the transmit stream and
// for regenerating the expected echo stream.
module uart_lb_pattern_gen
  import uart_lb_pkg::*;
#(
  parameter int              W          = 8,
  parameter logic [W-1:0]    RESET_SEED = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic [1:0]   mode,
  input  logic         advance,
  output logic [W-1:0] value
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = seed;
    end else if (advance) begin
      if (mode == LB_MODE_ROL) begin
        cnt_d = {cnt_q[W-2:0], cnt_q[W-1]};
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RESET_SEED;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Inverted mode keeps an ordinary counter and presents its complement.
  assign value = (mode == LB_MODE_INV) ? ~cnt_q : cnt_q;

endmodule

// File: rtl/uart_loopback_checker.sv
// UART echo-path traffic generator and checker with frame/error counters.
// Optional first-mismatch capture ports are enabled by defining UART_LB_FIRST_ERR_EN.
module uart_loopback_checker
  import uart_lb_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int COUNT_WIDTH     = 16,
  parameter int START_VALUE     = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_frames,
  input  logic [1:0]             pattern_mode,
  output logic [DATA_WIDTH-1:0]  tx_data,
  output logic                   tx_send,
  input  logic                   tx_ready,
  input  logic [DATA_WIDTH-1:0]  rx_data,
  input  logic                   rx_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] sent_count,
  output logic [COUNT_WIDTH-1:0] recv_count,
  output logic [COUNT_WIDTH-1:0] err_count
`ifdef UART_LB_FIRST_ERR_EN
  ,
  output logic                   first_err_valid,
  output logic [COUNT_WIDTH-1:0] first_err_index,
  output logic [DATA_WIDTH-1:0]  first_err_expected,
  output logic [DATA_WIDTH-1:0]  first_err_actual
`endif
);

  localparam int                     TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0]  SEED       = DATA_WIDTH'(START_VALUE);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [COUNT_WIDTH-1:0] MAX_OUT    = COUNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [TW-1:0]          TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  lb_state_e              state_q, state_d;
  logic [COUNT_WIDTH-1:0] num_q, num_d;
  logic [1:0]             mode_q, mode_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_send_q, tx_send_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_valid_prev_q, rx_valid_prev_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [COUNT_WIDTH-1:0] sent_count_q, sent_count_d;
  logic [COUNT_WIDTH-1:0] recv_count_q, recv_count_d;
  logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;
  logic                   timeout_q, timeout_d;
  logic [TW-1:0]          timer_q, timer_d;

  logic                   start_ok, active, rx_frame, rx_unsolicited, rx_mismatch;
  logic                   tx_fire, timer_run, timer_hit, tx_adv, exp_adv;
  logic [COUNT_WIDTH-1:0] outstanding;
  logic [DATA_WIDTH-1:0]  tx_value, exp_value;

  assign start_ok       = start && ((state_q == LB_IDLE) || (state_q == LB_DONE));
  assign active         = (state_q == LB_SEND) || (state_q == LB_DRAIN);
  assign outstanding    = sent_count_q - recv_count_q;
  assign rx_frame       = active && rx_valid_q && !rx_valid_prev_q;
  assign rx_unsolicited = (recv_count_q == sent_count_q);
  assign rx_mismatch    = rx_frame && !rx_unsolicited && (rx_data_q != exp_value);
  assign tx_fire        = (state_q == LB_SEND) && tx_ready && !tx_send_q &&
                          (sent_count_q != num_q) && (outstanding < MAX_OUT);
  assign timer_run      = (state_q == LB_DRAIN) ||
                          ((state_q == LB_SEND) && (outstanding != '0));
  assign timer_hit      = timer_run && !rx_frame && (timer_q == TIMER_LAST);
  assign tx_adv         = tx_send_q && !start_ok;
  assign exp_adv        = rx_frame && !rx_unsolicited;

  uart_lb_pattern_gen #(.W(DATA_WIDTH), .RESET_SEED(SEED)) u_tx_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .seed    (SEED),
    .mode    (mode_q),
    .advance (tx_adv),
    .value   (tx_value)
  );

  uart_lb_pattern_gen #(.W(DATA_WIDTH), .RESET_SEED(SEED)) u_exp_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .seed    (SEED),
    .mode    (mode_q),
    .advance (exp_adv),
    .value   (exp_value)
  );

  always_comb begin
    state_d         = state_q;
    num_d           = num_q;
    mode_d          = mode_q;
    tx_send_d       = tx_fire;
    tx_data_d       = tx_fire ? tx_value : tx_data_q;
    rx_valid_d      = rx_valid;
    rx_valid_prev_d = rx_valid_q;
    rx_data_d       = rx_data;
    sent_count_d    = sent_count_q;
    recv_count_d    = recv_count_q;
    err_count_d     = err_count_q;
    timeout_d       = timeout_q;
    timer_d         = (rx_frame || !timer_run) ? '0 : timer_q + TW'(1);

    // sent_count lags the pulse by one cycle, so outstanding uses pre-update values.
    if (tx_send_q && (sent_count_q != CNT_MAX)) begin
      sent_count_d = sent_count_q + COUNT_WIDTH'(1);
    end
    if (rx_frame) begin
      if ((rx_unsolicited || rx_mismatch) && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + COUNT_WIDTH'(1);
      end
      if (!rx_unsolicited && (recv_count_q != CNT_MAX)) begin
        recv_count_d = recv_count_q + COUNT_WIDTH'(1);
      end
    end

    case (state_q)
      LB_IDLE, LB_DONE: begin
        if (start_ok) begin
          state_d      = (num_frames == '0) ? LB_DONE : LB_SEND;
          num_d        = num_frames;
          mode_d       = pattern_mode;
          sent_count_d = '0;
          recv_count_d = '0;
          err_count_d  = '0;
          timeout_d    = 1'b0;
          timer_d      = '0;
        end
      end
      LB_SEND: begin
        if (timer_hit) begin
          state_d   = LB_DONE;
          timeout_d = 1'b1;
        end else if (sent_count_q == num_q) begin
          state_d = LB_DRAIN;
        end
      end
      LB_DRAIN: begin
        if (recv_count_q == sent_count_q) begin
          state_d = LB_DONE;
        end else if (timer_hit) begin
          state_d   = LB_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = LB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= LB_IDLE;
      num_q           <= '0;
      mode_q          <= LB_MODE_INC;
      tx_data_q       <= '0;
      tx_send_q       <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_valid_prev_q <= 1'b0;
      rx_data_q       <= '0;
      sent_count_q    <= '0;
      recv_count_q    <= '0;
      err_count_q     <= '0;
      timeout_q       <= 1'b0;
      timer_q         <= '0;
    end else begin
      state_q         <= state_d;
      num_q           <= num_d;
      mode_q          <= mode_d;
      tx_data_q       <= tx_data_d;
      tx_send_q       <= tx_send_d;
      rx_valid_q      <= rx_valid_d;
      rx_valid_prev_q <= rx_valid_prev_d;
      rx_data_q       <= rx_data_d;
      sent_count_q    <= sent_count_d;
      recv_count_q    <= recv_count_d;
      err_count_q     <= err_count_d;
      timeout_q       <= timeout_d;
      timer_q         <= timer_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_send    = tx_send_q;
  assign busy       = active;
  assign done       = (state_q == LB_DONE);
  assign pass       = done && (err_count_q == '0) && (recv_count_q == num_q) && !timeout_q;
  assign timeout    = timeout_q;
  assign sent_count = sent_count_q;
  assign recv_count = recv_count_q;
  assign err_count  = err_count_q;

`ifdef UART_LB_FIRST_ERR_EN
  // Only data mismatches are captured; unsolicited frames have no expected value.
  logic                   fe_valid_q, fe_valid_d;
  logic [COUNT_WIDTH-1:0] fe_index_q, fe_index_d;
  logic [DATA_WIDTH-1:0]  fe_exp_q, fe_exp_d;
  logic [DATA_WIDTH-1:0]  fe_act_q, fe_act_d;

  always_comb begin
    fe_valid_d = fe_valid_q;
    fe_index_d = fe_index_q;
    fe_exp_d   = fe_exp_q;
    fe_act_d   = fe_act_q;
    if (start_ok) begin
      fe_valid_d = 1'b0;
      fe_index_d = '0;
      fe_exp_d   = '0;
      fe_act_d   = '0;
    end else if (rx_mismatch && !fe_valid_q) begin
      fe_valid_d = 1'b1;
      fe_index_d = recv_count_q;
      fe_exp_d   = exp_value;
      fe_act_d   = rx_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_valid_q <= 1'b0;
      fe_index_q <= '0;
      fe_exp_q   <= '0;
      fe_act_q   <= '0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_index_q <= fe_index_d;
      fe_exp_q   <= fe_exp_d;
      fe_act_q   <= fe_act_d;
    end
  end

  assign first_err_valid    = fe_valid_q;
  assign first_err_index    = fe_index_q;
  assign first_err_expected = fe_exp_q;
  assign first_err_actual   = fe_act_q;
`endif

endmodule

// File: tb/tb_uart_loopback_checker.sv
// Self-checking bench: randomized UART echo environment plus an arithmetic
// model of the pattern stream and the expected counters.
module tb_uart_loopback_checker;

  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int SEED = 1;
  localparam int MAXO = 4;
  localparam int TOUT = 1000;
  localparam int BIG  = 1 << 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_frames;
  logic [1:0]    pattern_mode;
  logic [DW-1:0] tx_data;
  logic          tx_send;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] sent_count, recv_count, err_count;
`ifdef UART_LB_FIRST_ERR_EN
  logic          first_err_valid;
  logic [CW-1:0] first_err_index;
  logic [DW-1:0] first_err_expected, first_err_actual;
`endif

  uart_loopback_checker #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .START_VALUE(SEED),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .pattern_mode(pattern_mode), .tx_data(tx_data), .tx_send(tx_send),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count)
`ifdef UART_LB_FIRST_ERR_EN
    , .first_err_valid(first_err_valid), .first_err_index(first_err_index),
    .first_err_expected(first_err_expected), .first_err_actual(first_err_actual)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Control written only by the main sequence.
  bit tx_block = 1'b0;
  int echo_limit = BIG;
  int corrupt_idx = -1;
  int inj_req_cnt = 0;
  int run_start = 0;

  // Observations written only by the environment process.
  logic [DW-1:0] tx_log[$];
  int pulse_total = 0;
  int consec_viol = 0;
  int max_out_viol = 0;
  int last_rx_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pattern value for frame i: plain arithmetic on the seed.
  function automatic logic [DW-1:0] model(input int mode, input int i);
    logic [DW-1:0] s;
    logic [2*DW-1:0] w;
    s = DW'(SEED);
    case (mode)
      1:       begin w = {s, s} << (i % DW); return w[2*DW-1:DW]; end
      2:       return ~DW'(SEED + i);
      default: return DW'(SEED + i);
    endcase
  endfunction

  // UART tx/rx environment: busy period after each send, delayed echo with
  // optional corruption, frame dropping, and injected unsolicited frames.
  initial begin : env
    int busy_cnt = 0;
    int hold = 0;
    int low = 0;
    int inj_done = 0;
    int idx;
    bit prev = 1'b0;
    logic [DW-1:0] echo_q[$];
    int echo_due[$];
    tx_ready = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0; hold = 0; low = 0; prev = 1'b0;
        inj_done = inj_req_cnt;
        echo_q.delete(); echo_due.delete();
        rx_valid = 1'b0;
        tx_ready = !tx_block;
      end else begin
        if (tx_send === 1'b1) begin
          if (prev) consec_viol++;
          idx = pulse_total - run_start;
          pulse_total++;
          tx_log.push_back(tx_data);
          if (idx < echo_limit) begin
            echo_q.push_back((idx == corrupt_idx) ? (tx_data ^ 8'h80) : tx_data);
            echo_due.push_back(cyc + int'($urandom_range(1, 8)));
          end
          busy_cnt = int'($urandom_range(1, 6));
        end
        prev = (tx_send === 1'b1);
        if (busy_cnt > 0) busy_cnt--;
        tx_ready = !tx_block && (busy_cnt == 0);
        if ((int'(sent_count) - int'(recv_count)) > MAXO) max_out_viol++;

        if (hold > 0) begin
          hold--;
          if (hold == 0) begin rx_valid = 1'b0; low = 1; end
        end else if (low > 0) begin
          low--;
        end else if (inj_done != inj_req_cnt) begin
          rx_data = 8'h55; rx_valid = 1'b1; hold = 2; inj_done++;
          last_rx_cyc = cyc;
        end else if (echo_q.size() > 0 && cyc >= echo_due[0]) begin
          rx_data = echo_q.pop_front();
          void'(echo_due.pop_front());
          rx_valid = 1'b1;
          hold = int'($urandom_range(1, 3));
          last_rx_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_done(input int budget, output int done_cyc);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1'b1);
    done_cyc = cyc;
  endtask

  task automatic launch(input int num, input int mode, input int corrupt, input int limit,
                        output int base);
    corrupt_idx = corrupt;
    echo_limit  = limit;
    base        = tx_log.size();
    run_start   = pulse_total;
    num_frames  = CW'(num);
    pattern_mode = 2'(mode);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic finish_run(input int num, input int mode, input int corrupt, input int limit,
                            input int extra_err, input int base);
    int exp_sent, exp_recv, exp_err, done_cyc, dt;
    bit exp_to;
    wait_done(8000, done_cyc);
    exp_to   = (limit < num);
    exp_recv = exp_to ? limit : num;
    exp_sent = exp_to ? ((limit + MAXO < num) ? limit + MAXO : num) : num;
    exp_err  = ((corrupt >= 0 && corrupt < exp_recv) ? 1 : 0) + extra_err;
    chk("sent_count", sent_count, exp_sent);
    chk("recv_count", recv_count, exp_recv);
    chk("err_count", err_count, exp_err);
    chk("timeout", timeout, exp_to);
    chk("busy_in_done", busy, 1'b0);
    chk("pass", pass, (!exp_to && exp_err == 0));
    chk("tx_frames", tx_log.size() - base, exp_sent);
    for (int i = 0; i < exp_sent && (base + i) < tx_log.size(); i++) begin
      chk($sformatf("tx_data[%0d]", i), tx_log[base + i], model(mode, i));
    end
    if (exp_to) begin
      dt = done_cyc - last_rx_cyc;
      chk("timeout_latency_in_window", (dt >= TOUT - 5 && dt <= TOUT + 60), 1'b1);
    end
`ifdef UART_LB_FIRST_ERR_EN
    chk("first_err_valid", first_err_valid, (corrupt >= 0 && corrupt < exp_recv));
    if (corrupt >= 0 && corrupt < exp_recv) begin
      chk("first_err_index", first_err_index, corrupt);
      chk("first_err_expected", first_err_expected, model(mode, corrupt));
      chk("first_err_actual", first_err_actual, model(mode, corrupt) ^ 8'h80);
    end
`endif
  endtask

  task automatic do_run(input int num, input int mode, input int corrupt, input int limit);
    int base;
    launch(num, mode, corrupt, limit, base);
    finish_run(num, mode, corrupt, limit, 0, base);
  endtask

  initial begin : main
    int base, num, mode, corrupt, p0, dc;
    rst = 1'b1; start = 1'b0; num_frames = '0; pattern_mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_send", tx_send, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_counts", {sent_count, recv_count, err_count}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_run(16, 0, -1, BIG);
    do_run(16, 0, 4, BIG);
    do_run(9, 1, -1, BIG);
    do_run(260, 0, -1, BIG);
    do_run(12, 2, -1, BIG);
    do_run(10, 3, -1, BIG);
    for (int r = 0; r < 3; r++) begin
      num  = int'($urandom_range(1, 40));
      mode = int'($urandom_range(0, 3));
      corrupt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, num - 1)) : -1;
      do_run(num, mode, corrupt, BIG);
    end

    // Echo path stalls after three frames.
    do_run(16, 0, -1, 3);

    // Unsolicited frame before anything was sent, then a start while busy.
    tx_block = 1'b1;
    repeat (2) @(negedge clk);
    launch(4, 0, -1, BIG, base);
    repeat (4) @(negedge clk);
    chk("unsol_sent_before", sent_count, 0);
    inj_req_cnt++;
    repeat (10) @(negedge clk);
    chk("unsol_err", err_count, 1);
    chk("unsol_recv", recv_count, 0);
    num_frames = CW'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_while_busy_ignored", busy, 1'b1);
    chk("start_while_busy_err_kept", err_count, 1);
    tx_block = 1'b0;
    finish_run(4, 0, -1, BIG, 1, base);

    // Reset mid-SEND, then an empty run.
    launch(50, 0, -1, BIG, base);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_tx_send", tx_send, 1'b0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_counts", {sent_count, recv_count, err_count}, 0);
    chk("midrst_done_pass", {done, pass, timeout}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    num_frames = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    p0 = pulse_total;
    chk("zero_done", done, 1'b1);
    chk("zero_pass", pass, 1'b1);
    chk("zero_busy", busy, 1'b0);
    repeat (6) @(negedge clk);
    chk("zero_no_tx_send", pulse_total - p0, 0);
    chk("zero_sent", sent_count, 0);
    wait_done(4, dc);

    chk("no_consecutive_tx_send", consec_viol, 0);
    chk("outstanding_within_limit", max_out_viol, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
